// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch stage
package fetch_pkg;

  localparam int unsigned XLEN     = 32;
  localparam logic [31:0] PC_STEP  = 32'd4;
  localparam logic [31:0] NOP_INSN = 32'h0000_0000;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    HOLD = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  // Output-register update selector driven by the fetch FSM
  typedef enum logic [2:0] {
    OUT_HOLD   = 3'd0,
    OUT_MEM    = 3'd1,
    OUT_BUF    = 3'd2,
    OUT_BUBBLE = 3'd3,
    OUT_FLUSH  = 3'd4
  } out_ctl_t;

endpackage

// File: rtl/fetch_skid_reg.sv
// rtl/fetch_skid_reg.sv - hold buffer plus IF/ID output register
module fetch_skid_reg
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_VAL = NOP_INSN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  out_ctl_t        ctl,
  input  logic            buf_load,
  input  logic [XLEN-1:0] rdata,
  input  logic [XLEN-1:0] addrs_in,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] addrs,
  output logic            valid
);

  logic [XLEN-1:0] hold_buf_q, hold_buf_d;
  logic [XLEN-1:0] insn_q, insn_d;
  logic [XLEN-1:0] addrs_q, addrs_d;
  logic            valid_q, valid_d;

  // Next-state selection for the buffer and the visible output registers
  always_comb begin
    hold_buf_d = hold_buf_q;
    insn_d     = insn_q;
    addrs_d    = addrs_q;
    valid_d    = valid_q;
    if (buf_load) hold_buf_d = rdata;
    unique case (ctl)
      OUT_MEM: begin
        insn_d  = rdata;
        addrs_d = addrs_in;
        valid_d = 1'b1;
      end
      OUT_BUF: begin
        insn_d  = hold_buf_q;
        addrs_d = addrs_in;
        valid_d = 1'b1;
      end
      OUT_BUBBLE: begin
        insn_d  = NOP_VAL;
        valid_d = 1'b0;
      end
      OUT_FLUSH: begin
        insn_d     = NOP_VAL;
        addrs_d    = '0;
        valid_d    = 1'b0;
        hold_buf_d = NOP_VAL;
      end
      default: ;
    endcase
  end

  // Register state with asynchronous reset to the flushed value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_buf_q <= NOP_VAL;
      insn_q     <= NOP_VAL;
      addrs_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      hold_buf_q <= hold_buf_d;
      insn_q     <= insn_d;
      addrs_q    <= addrs_d;
      valid_q    <= valid_d;
    end
  end

  assign instruction = insn_q;
  assign addrs       = addrs_q;
  assign valid       = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC, imem handshake FSM, stall and redirect handling
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] STEP      = PC_STEP,
  parameter logic [31:0] NOP_VALUE = NOP_INSN
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  output logic [31:0] instruction,
  output logic [31:0] addrs,
  output logic        valid
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  fetch_addr_q, fetch_addr_d;
  logic [31:0]  next_addr;
  logic [31:0]  target;
  out_ctl_t     out_ctl;
  logic         buf_load;

  assign next_addr = fetch_addr_q + STEP;
  assign target    = redirect_addr & ~32'h3;

  // Held low during reset so the first request appears right after release
  assign imem_req  = rst_n && (state_q != HOLD);
  assign imem_addr = fetch_addr_q;

  // Next-state, PC and output-register control; redirect always wins
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_addr_d = fetch_addr_q;
    out_ctl      = OUT_HOLD;
    buf_load     = 1'b0;
    unique case (state_q)
      REQ: begin
        if (redirect) begin
          out_ctl = OUT_FLUSH;
          pc_d    = target;
          if (imem_ready) begin
            fetch_addr_d = target;
          end else begin
            // Keep imem_addr stable until the outstanding response lands
            state_d = DROP;
          end
        end else if (imem_ready) begin
          if (!stall) begin
            out_ctl      = OUT_MEM;
            pc_d         = next_addr;
            fetch_addr_d = next_addr;
          end else begin
            buf_load = 1'b1;
            state_d  = HOLD;
          end
        end else if (!stall) begin
          out_ctl = OUT_BUBBLE;
        end
      end
      HOLD: begin
        if (redirect) begin
          out_ctl      = OUT_FLUSH;
          pc_d         = target;
          fetch_addr_d = target;
          state_d      = REQ;
        end else if (!stall) begin
          out_ctl      = OUT_BUF;
          pc_d         = next_addr;
          fetch_addr_d = next_addr;
          state_d      = REQ;
        end
      end
      DROP: begin
        out_ctl = OUT_FLUSH;
        if (redirect) pc_d = target;
        if (imem_ready) begin
          // A redirect landing with the response still wins over the older pc
          fetch_addr_d = redirect ? target : pc_q;
          state_d      = REQ;
        end
      end
      default: state_d = REQ;
    endcase
  end

  // State, PC and fetch address registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= REQ;
      pc_q         <= RESET_PC;
      fetch_addr_q <= RESET_PC;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_addr_q <= fetch_addr_d;
    end
  end

  fetch_skid_reg #(
    .NOP_VAL(NOP_VALUE)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .ctl        (out_ctl),
    .buf_load   (buf_load),
    .rdata      (imem_rdata),
    .addrs_in   (next_addr),
    .instruction(instruction),
    .addrs      (addrs),
    .valid      (valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - table-driven bench for fetch_stage
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic [31:0] instruction;
  logic [31:0] addrs;
  logic        valid;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        ready;
    logic        stall;
    logic        redir;
    logic [31:0] raddr;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_insn;
    logic [31:0] e_addrs;
  } vec_t;

  vec_t vecs[24];

  fetch_stage #(
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_addr(redirect_addr),
    .instruction  (instruction),
    .addrs        (addrs),
    .valid        (valid)
  );

  // Memory returns a word derived from its address
  assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   {31'd0, imem_req}, 32'd0);
    check({tag, "_valid"}, {31'd0, valid},    32'd0);
    check({tag, "_insn"},  instruction,       32'h0);
    check({tag, "_addrs"}, addrs,             32'h0);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    imem_ready = 1'b0;
    stall      = 1'b0;
    redirect   = 1'b0;
    #1;
    check_reset_outputs("rst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input int i);
    imem_ready    = vecs[i].ready;
    stall         = vecs[i].stall;
    redirect      = vecs[i].redir;
    redirect_addr = vecs[i].raddr;
    #1;
    check($sformatf("v%0d_req", i),  {31'd0, imem_req}, {31'd0, vecs[i].e_req});
    check($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
    @(posedge clk);
    #1;
    check($sformatf("v%0d_valid", i), {31'd0, valid}, {31'd0, vecs[i].e_valid});
    check($sformatf("v%0d_insn", i),  instruction, vecs[i].e_insn);
    check($sformatf("v%0d_addrs", i), addrs, vecs[i].e_addrs);
  endtask

  initial begin
    // ready stall redir raddr | req addr | valid insn addrs
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         1'b1, 32'hA5A5_0000, 32'h4};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h4,         1'b1, 32'hA5A5_0004, 32'h8};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h8,         1'b1, 32'hA5A5_0008, 32'hC};
    // after reset: wait states on 0x4
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         1'b1, 32'hA5A5_0000, 32'h4};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h4,         1'b0, 32'h0,         32'h4};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h4,         1'b0, 32'h0,         32'h4};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h4,         1'b1, 32'hA5A5_0004, 32'h8};
    // stall at ready for 0x8
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h8,         1'b1, 32'hA5A5_0004, 32'h8};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h8,         1'b1, 32'hA5A5_0004, 32'h8};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h8,         1'b1, 32'hA5A5_0008, 32'hC};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'hC,         1'b1, 32'hA5A5_000C, 32'h10};
    // redirect to 0x100 while 0x10 pending
    vecs[11] = '{1'b0, 1'b0, 1'b1, 32'h100,       1'b1, 32'h10,        1'b0, 32'h0,         32'h0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h10,        1'b0, 32'h0,         32'h0};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h10,        1'b0, 32'h0,         32'h0};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h100,       1'b1, 32'hA5A5_0100, 32'h104};
    // redirect to unaligned 0x203 with stall and ready
    vecs[15] = '{1'b1, 1'b1, 1'b1, 32'h203,       1'b1, 32'h104,       1'b0, 32'h0,         32'h0};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h200,       1'b1, 32'hA5A5_0200, 32'h204};
    // wrap at top of address space
    vecs[17] = '{1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h204,       1'b0, 32'h0,         32'h0};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b1, 32'h5A5A_FFFC, 32'h0};
    vecs[19] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         1'b1, 32'hA5A5_0000, 32'h4};
    // second redirect while dropping only moves pc
    vecs[20] = '{1'b0, 1'b0, 1'b1, 32'h40,        1'b1, 32'h4,         1'b0, 32'h0,         32'h0};
    vecs[21] = '{1'b0, 1'b0, 1'b1, 32'h80,        1'b1, 32'h4,         1'b0, 32'h0,         32'h0};
    vecs[22] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h4,         1'b0, 32'h0,         32'h0};
    vecs[23] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h80,        1'b1, 32'hA5A5_0080, 32'h84};

    redirect_addr = 32'h0;
    do_reset();
    for (int i = 0; i < 24; i++) begin
      if (i == 3) do_reset();
      run_vec(i);
    end

    // Reset asserted mid-wait: outputs clear without a clock edge
    imem_ready = 1'b0;
    stall      = 1'b0;
    redirect   = 1'b0;
    @(posedge clk);
    #1;
    check("midwait_addr", imem_addr, 32'h84);
    check("midwait_valid", {31'd0, valid}, 32'd0);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    check("async_addr", imem_addr, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_req",  {31'd0, imem_req}, 32'd1);
    check("post_rst_addr", imem_addr, 32'h0);
    imem_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_insn",  instruction, 32'hA5A5_0000);
    check("post_rst_addrs", addrs, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
